rotary_decoder: RTL and testbench



---
 rtl/rotary_decoder_if.sv | 46 ++++
 rtl/rotary_decoder.sv | 188 ++++++++++++++++++
 tb/tb_rotary_decoder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rotary_decoder_if.sv
// Signal bundle between the rotary encoder pins, the rotary_decoder front end and the
// rotary instruction controller. illegal_count exists only with ROTARY_DECODER_ERRCNT_EN.
interface rotary_decoder_if #(
    parameter int ERRCNT_WIDTH = 8
);
    logic [1:0] rotary;
    logic       rotary_left;
    logic       rotary_right;
    logic [1:0] rotary_filtered;

`ifdef ROTARY_DECODER_ERRCNT_EN
    logic [ERRCNT_WIDTH-1:0] illegal_count;

    modport master (
        output rotary,
        input  rotary_left,
        input  rotary_right,
        input  rotary_filtered,
        input  illegal_count
    );

    modport slave (
        input  rotary,
        output rotary_left,
        output rotary_right,
        output rotary_filtered,
        output illegal_count
    );
`else
    localparam int ERRCNT_WIDTH_UNUSED = ERRCNT_WIDTH;

    modport master (
        output rotary,
        input  rotary_left,
        input  rotary_right,
        input  rotary_filtered
    );

    modport slave (
        input  rotary,
        output rotary_left,
        output rotary_right,
        output rotary_filtered
    );
`endif
endinterface

// File: rtl/rotary_decoder.sv
// Quadrature encoder front end: two-flop synchroniser, per-pin debounce, detent decoder FSM.
// Optional saturating illegal-transition counter enabled by ROTARY_DECODER_ERRCNT_EN.
module rotary_decoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DEBOUNCE_WIDTH  = 5,
    parameter int ERRCNT_WIDTH    = 8
) (
    input  logic               clock,
    input  logic               reset,
    rotary_decoder_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_R1     = 3'd1,
        ST_R2     = 3'd2,
        ST_R3     = 3'd3,
        ST_L1     = 3'd4,
        ST_L2     = 3'd5,
        ST_L3     = 3'd6,
        ST_RESYNC = 3'd7
    } state_t;

    localparam logic [DEBOUNCE_WIDTH-1:0] CNT_ZERO = {DEBOUNCE_WIDTH{1'b0}};
    localparam logic [DEBOUNCE_WIDTH-1:0] CNT_ONE  = {{(DEBOUNCE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DEBOUNCE_WIDTH-1:0] CNT_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [1:0]                s1_r;
    logic [1:0]                s2_r;
    logic [1:0]                filtered_r;
    logic [1:0]                prev_filtered_r;
    logic [DEBOUNCE_WIDTH-1:0] cnt_r [0:1];
    state_t                    state_r;
    state_t                    state_next_s;
    logic                      left_r;
    logic                      right_r;
    logic                      left_next_s;
    logic                      right_next_s;
    logic                      illegal_s;
    logic [1:0]                change_s;

    // Two-stage synchroniser for the asynchronous encoder pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_r <= 2'b00;
            s2_r <= 2'b00;
        end else begin
            s1_r <= bus.rotary;
            s2_r <= s1_r;
        end
    end

    // Per-pin debounce: a new level must persist DEBOUNCE_CYCLES samples; any bounce restarts.
    always_ff @(posedge clock) begin
        if (reset) begin
            filtered_r <= 2'b00;
            cnt_r[0]   <= CNT_ZERO;
            cnt_r[1]   <= CNT_ZERO;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (s2_r[p] == filtered_r[p]) begin
                    cnt_r[p] <= CNT_ZERO;
                end else if (cnt_r[p] == CNT_LAST) begin
                    filtered_r[p] <= s2_r[p];
                    cnt_r[p]      <= CNT_ZERO;
                end else begin
                    cnt_r[p] <= cnt_r[p] + CNT_ONE;
                end
            end
        end
    end

    assign change_s = filtered_r ^ prev_filtered_r;

    // Next-state and pulse decode from the latest filtered-level change.
    always_comb begin
        state_next_s = state_r;
        left_next_s  = 1'b0;
        right_next_s = 1'b0;
        illegal_s    = 1'b0;
        if (state_r == ST_RESYNC) begin
            // Changes are ignored here; only a return to the rest level re-arms decoding.
            if (filtered_r == 2'b00) begin
                state_next_s = ST_IDLE;
            end else begin
                state_next_s = ST_RESYNC;
            end
        end else if (change_s == 2'b00) begin
            state_next_s = state_r;
        end else if (change_s == 2'b11) begin
            state_next_s = ST_RESYNC;
            illegal_s    = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (filtered_r == 2'b01)      state_next_s = ST_R1;
                    else if (filtered_r == 2'b10) state_next_s = ST_L1;
                    else                          state_next_s = ST_RESYNC;
                end
                ST_R1: begin
                    if (filtered_r == 2'b11)      state_next_s = ST_R2;
                    else if (filtered_r == 2'b00) state_next_s = ST_IDLE;
                    else                          state_next_s = ST_RESYNC;
                end
                ST_R2: begin
                    if (filtered_r == 2'b10)      state_next_s = ST_R3;
                    else if (filtered_r == 2'b01) state_next_s = ST_R1;
                    else                          state_next_s = ST_RESYNC;
                end
                ST_R3: begin
                    if (filtered_r == 2'b00) begin
                        state_next_s = ST_IDLE;
                        right_next_s = 1'b1;
                    end else if (filtered_r == 2'b11) begin
                        state_next_s = ST_R2;
                    end else begin
                        state_next_s = ST_RESYNC;
                    end
                end
                ST_L1: begin
                    if (filtered_r == 2'b11)      state_next_s = ST_L2;
                    else if (filtered_r == 2'b00) state_next_s = ST_IDLE;
                    else                          state_next_s = ST_RESYNC;
                end
                ST_L2: begin
                    if (filtered_r == 2'b01)      state_next_s = ST_L3;
                    else if (filtered_r == 2'b10) state_next_s = ST_L1;
                    else                          state_next_s = ST_RESYNC;
                end
                ST_L3: begin
                    if (filtered_r == 2'b00) begin
                        state_next_s = ST_IDLE;
                        left_next_s  = 1'b1;
                    end else if (filtered_r == 2'b11) begin
                        state_next_s = ST_L2;
                    end else begin
                        state_next_s = ST_RESYNC;
                    end
                end
                default: state_next_s = ST_RESYNC;
            endcase
        end
    end

    // State register, previous filtered level and registered direction pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= ST_RESYNC;
            prev_filtered_r <= 2'b00;
            left_r          <= 1'b0;
            right_r         <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            prev_filtered_r <= filtered_r;
            left_r          <= left_next_s;
            right_r         <= right_next_s;
        end
    end

    assign bus.rotary_left     = left_r;
    assign bus.rotary_right    = right_r;
    assign bus.rotary_filtered = filtered_r;

`ifdef ROTARY_DECODER_ERRCNT_EN
    localparam logic [ERRCNT_WIDTH-1:0] ERR_MAX = {ERRCNT_WIDTH{1'b1}};
    localparam logic [ERRCNT_WIDTH-1:0] ERR_ONE = {{(ERRCNT_WIDTH-1){1'b0}}, 1'b1};

    logic [ERRCNT_WIDTH-1:0] illegal_count_r;

    // Saturating count of illegal two-pin jumps; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            illegal_count_r <= {ERRCNT_WIDTH{1'b0}};
        end else if (illegal_s && (illegal_count_r != ERR_MAX)) begin
            illegal_count_r <= illegal_count_r + ERR_ONE;
        end else begin
            illegal_count_r <= illegal_count_r;
        end
    end

    assign bus.illegal_count = illegal_count_r;
`else
    localparam int ERRCNT_WIDTH_UNUSED = ERRCNT_WIDTH;
    logic illegal_unused_s;
    assign illegal_unused_s = illegal_s;
`endif

endmodule

// File: tb/tb_rotary_decoder.sv
// Bench for rotary_decoder: hand table of detent segments, timing corner cases and
// random pin activity checked each cycle against a phase-counting reference model.
module tb_rotary_decoder;
    localparam int D  = 4;
    localparam int EW = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    rotary_decoder_if #(.ERRCNT_WIDTH(EW)) bus ();

    rotary_decoder #(
        .DEBOUNCE_CYCLES(D),
        .DEBOUNCE_WIDTH (5),
        .ERRCNT_WIDTH   (EW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Reference model state: pin delay line, sample window, filtered level, detent position.
    logic [1:0] m_s1, m_s2, m_filt, m_prev;
    logic [1:0] hq[$];
    int         m_pos;
    bit         m_resync;
    bit         m_left, m_right;
    int         m_err;

    function automatic int phase(input logic [1:0] l);
        case (l)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] level_of(input int ph);
        case (ph & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_edge(input logic [1:0] v, input logic r);
        int d;
        bit all_diff;
        if (r) begin
            m_s1 = 2'b00; m_s2 = 2'b00; m_filt = 2'b00; m_prev = 2'b00;
            hq.delete();
            m_pos = 0; m_resync = 1'b1; m_left = 1'b0; m_right = 1'b0; m_err = 0;
        end else begin
            m_left = 1'b0;
            m_right = 1'b0;
            if (m_resync) begin
                if (m_filt == 2'b00) begin
                    m_resync = 1'b0;
                    m_pos = 0;
                end
            end else begin
                d = (phase(m_filt) - phase(m_prev) + 4) % 4;
                if (d == 2) begin
                    m_resync = 1'b1;
                    if (m_err < (1 << EW) - 1) m_err++;
                end else if (d == 1) begin
                    m_pos++;
                end else if (d == 3) begin
                    m_pos--;
                end
                if (m_pos == 4) begin
                    m_right = 1'b1; m_pos = 0;
                end else if (m_pos == -4) begin
                    m_left = 1'b1; m_pos = 0;
                end
            end
            m_prev = m_filt;
            hq.push_back(m_s2);
            if (hq.size() > D) void'(hq.pop_front());
            if (hq.size() == D) begin
                for (int p = 0; p < 2; p++) begin
                    all_diff = 1'b1;
                    for (int i = 0; i < D; i++) if (hq[i][p] == m_filt[p]) all_diff = 1'b0;
                    if (all_diff) m_filt[p] = ~m_filt[p];
                end
            end
            m_s2 = m_s1;
            m_s1 = v;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] v, input logic r);
        @(negedge clock);
        bus.rotary = v;
        reset      = r;
        @(posedge clock);
        model_edge(v, r);
        #1;
        check("rotary_left", int'(bus.rotary_left), int'(m_left));
        check("rotary_right", int'(bus.rotary_right), int'(m_right));
        check("rotary_filtered", int'(bus.rotary_filtered), int'(m_filt));
        check("pulse_exclusive", int'(bus.rotary_left & bus.rotary_right), 0);
`ifdef ROTARY_DECODER_ERRCNT_EN
        check("illegal_count", int'(bus.illegal_count), m_err);
`endif
    endtask

    task automatic hold(input logic [1:0] v, input int n, output int nl, output int nr);
        nl = 0; nr = 0;
        for (int h = 0; h < n; h++) begin
            step(v, 1'b0);
            nl += int'(bus.rotary_left);
            nr += int'(bus.rotary_right);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] lvl;
        int         cycles;
        int         exp_l;
        int         exp_r;
        logic [1:0] exp_f;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int nl, nr, tl, tr, cur, sel, n;
        logic [1:0] lv;
        bus.rotary = 2'b00;

        // reset and idle
        tbl.push_back('{1'b1, 2'b00, 2, 0, 0, 2'b00});
        tbl.push_back('{1'b0, 2'b00, 50, 0, 0, 2'b00});
        // clockwise detent
        tbl.push_back('{1'b0, 2'b01, 10, 0, 0, 2'b01});
        tbl.push_back('{1'b0, 2'b11, 10, 0, 0, 2'b11});
        tbl.push_back('{1'b0, 2'b10, 10, 0, 0, 2'b10});
        tbl.push_back('{1'b0, 2'b00, 10, 0, 1, 2'b00});
        // counter-clockwise detent
        tbl.push_back('{1'b0, 2'b10, 10, 0, 0, 2'b10});
        tbl.push_back('{1'b0, 2'b11, 10, 0, 0, 2'b11});
        tbl.push_back('{1'b0, 2'b01, 10, 0, 0, 2'b01});
        tbl.push_back('{1'b0, 2'b00, 10, 1, 0, 2'b00});
        // pin A bounce shorter than the debounce window
        tbl.push_back('{1'b0, 2'b01, 1, 0, 0, 2'b00});
        tbl.push_back('{1'b0, 2'b00, 1, 0, 0, 2'b00});
        tbl.push_back('{1'b0, 2'b01, 1, 0, 0, 2'b00});
        tbl.push_back('{1'b0, 2'b00, 10, 0, 0, 2'b00});
        // reversal, then a full clockwise detent
        tbl.push_back('{1'b0, 2'b01, 10, 0, 0, 2'b01});
        tbl.push_back('{1'b0, 2'b11, 10, 0, 0, 2'b11});
        tbl.push_back('{1'b0, 2'b01, 10, 0, 0, 2'b01});
        tbl.push_back('{1'b0, 2'b00, 10, 0, 0, 2'b00});
        tbl.push_back('{1'b0, 2'b01, 10, 0, 0, 2'b01});
        tbl.push_back('{1'b0, 2'b11, 10, 0, 0, 2'b11});
        tbl.push_back('{1'b0, 2'b10, 10, 0, 0, 2'b10});
        tbl.push_back('{1'b0, 2'b00, 10, 0, 1, 2'b00});
        // reset while mid-detent
        tbl.push_back('{1'b0, 2'b01, 10, 0, 0, 2'b01});
        tbl.push_back('{1'b0, 2'b11, 10, 0, 0, 2'b11});
        tbl.push_back('{1'b1, 2'b11, 1, 0, 0, 2'b00});
        tbl.push_back('{1'b0, 2'b10, 10, 0, 0, 2'b10});
        tbl.push_back('{1'b0, 2'b00, 10, 0, 0, 2'b00});

        for (int k = 0; k < tbl.size(); k++) begin
            nl = 0; nr = 0;
            for (int h = 0; h < tbl[k].cycles; h++) begin
                step(tbl[k].lvl, tbl[k].rst);
                nl += int'(bus.rotary_left);
                nr += int'(bus.rotary_right);
            end
            check($sformatf("tbl%0d_left_pulses", k), nl, tbl[k].exp_l);
            check($sformatf("tbl%0d_right_pulses", k), nr, tbl[k].exp_r);
            check($sformatf("tbl%0d_filtered", k), int'(bus.rotary_filtered), int'(tbl[k].exp_f));
        end

        // right pulse lands exactly at edge 2+D after 00 enters s1, one cycle wide
        hold(2'b01, 10, nl, nr);
        hold(2'b11, 10, nl, nr);
        hold(2'b10, 10, nl, nr);
        for (int i = 0; i < 10; i++) begin
            step(2'b00, 1'b0);
            check($sformatf("pulse_timing_edge%0d", i), int'(bus.rotary_right), (i == 2 + D) ? 1 : 0);
            check("pulse_timing_left", int'(bus.rotary_left), 0);
        end

        // illegal two-pin jump, then recovery through 00 and a clockwise detent
        hold(2'b11, 10, nl, nr);
        check("illegal_no_pulse", nl + nr, 0);
`ifdef ROTARY_DECODER_ERRCNT_EN
        check("illegal_count_one", int'(bus.illegal_count), 1);
`endif
        hold(2'b00, 10, nl, nr);
        check("resync_exit_no_pulse", nl + nr, 0);
        tl = 0; tr = 0;
        for (int ph = 1; ph <= 4; ph++) begin
            hold(level_of(ph), 10, nl, nr);
            tl += nl; tr += nr;
        end
        check("recovery_right", tr, 1);
        check("recovery_left", tl, 0);
`ifdef ROTARY_DECODER_ERRCNT_EN
        check("illegal_count_held", int'(bus.illegal_count), 1);
`endif

        // random walk: mostly Gray steps, some short bounces, jumps and resets
        cur = 0;
        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 99);
            if (sel < 2) begin
                step(level_of(cur), 1'b1);
            end else begin
                if (sel < 45)      cur = cur + 1;
                else if (sel < 80) cur = cur + 3;
                else if (sel < 90) cur = cur + 2;
                lv = level_of(cur);
                n  = $urandom_range(1, 3 * D);
                for (int h = 0; h < n; h++) step(lv, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
